// File: rtl/xpb_table_gen_if.sv
// Write-port and control bundle for the xpb table generator.
// master = generator side (drives the write port), slave = sink/controller side.
// All signals are plain logic; the clock and reset stay outside the bundle.
interface xpb_table_gen_if #(
    parameter int WIDTH     = 1024,
    parameter int ADDR_BITS = 5
);
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [WIDTH-1:0]     modulus;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [WIDTH-1:0]     wr_data;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        input  start, base, modulus, wr_ready,
        output wr_valid, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        output start, base, modulus, wr_ready,
        input  wr_valid, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/xpb_table_gen.sv
// Purpose: emits entry[k] = (k*base) mod modulus, k = 0..2**ADDR_BITS-1, on a valid/ready write port.
// Latency: entry k valid 1+3k cycles after the accepted start; done pulses one cycle after the last handshake.
// Backpressure: waits in WRITE with addr/data/valid frozen until wr_ready; optional XPB_GEN_RANGE_CHECK_EN flags bad operands.
module xpb_table_gen #(
    parameter int WIDTH     = 1024,
    parameter int ADDR_BITS = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    xpb_table_gen_if.master  xpb_bus
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_ADD   = 3'd2,
        S_SUB   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_base;
    logic [WIDTH-1:0]     r_mod;
    logic [WIDTH-1:0]     r_acc;
    logic [WIDTH:0]       r_sum;
    logic [ADDR_BITS-1:0] r_addr;
    logic                 r_wr_valid;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_hs;
    logic                 w_range_bad;
    logic [WIDTH:0]       w_diff;
    logic                 w_ge;

    // The accumulator is the table entry itself, so it doubles as write data.
    assign xpb_bus.wr_valid = r_wr_valid;
    assign xpb_bus.wr_addr  = r_addr;
    assign xpb_bus.wr_data  = r_acc;
    assign xpb_bus.busy     = r_busy;
    assign xpb_bus.done     = r_done;

    assign w_hs   = r_wr_valid & xpb_bus.wr_ready;
    // Sum keeps its carry bit, so the compare and subtract are done at WIDTH+1.
    assign w_ge   = (r_sum >= {1'b0, r_mod});
    assign w_diff = r_sum - {1'b0, r_mod};

`ifdef XPB_GEN_RANGE_CHECK_EN
    logic r_err;

    assign w_range_bad = (xpb_bus.base >= xpb_bus.modulus) || (xpb_bus.modulus == '0);
    assign xpb_bus.err = r_err;

    // Error flag: re-evaluated on every accepted start, held otherwise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if ((r_state == S_IDLE) && xpb_bus.start) begin
            r_err <= w_range_bad;
        end
    end
`else
    // Without the check, bad operands just produce meaningless entries.
    assign w_range_bad = 1'b0;
    assign xpb_bus.err = 1'b0;
`endif

    // Main FSM: one entry costs WRITE -> ADD -> SUB, i.e. three cycles at full rate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_mod      <= '0;
            r_acc      <= '0;
            r_sum      <= '0;
            r_addr     <= '0;
            r_wr_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (xpb_bus.start) begin
                        r_base <= xpb_bus.base;
                        r_mod  <= xpb_bus.modulus;
                        r_acc  <= '0;
                        r_addr <= '0;
                        r_busy <= 1'b1;
                        if (w_range_bad) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_wr_valid <= 1'b1;
                            r_state    <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_hs) begin
                        r_wr_valid <= 1'b0;
                        if (r_addr == LAST_ADDR) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_ADD;
                        end
                    end
                end
                S_ADD: begin
                    r_sum   <= {1'b0, r_acc} + {1'b0, r_base};
                    r_state <= S_SUB;
                end
                S_SUB: begin
                    // acc and base are both below modulus, so one subtract is enough.
                    if (w_ge) begin
                        r_acc <= w_diff[WIDTH-1:0];
                    end else begin
                        r_acc <= r_sum[WIDTH-1:0];
                    end
                    r_addr     <= r_addr + ADDR_BITS'(1);
                    r_wr_valid <= 1'b1;
                    r_state    <= S_WRITE;
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_wr_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
